// File: rtl/kamus_l1d_ram.sv
// L1 data memory responder: combinational read, byte-lane synchronous write,
// post-reset clear sweep, and access fault detection with first-fault capture.
module kamus_l1d_ram #(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        l1d_rd_en_i,
  input  logic        l1d_wr_en_i,
  input  logic [31:0] l1d_addr_i,
  input  logic [1:0]  l1d_size_i,
  input  logic [31:0] l1d_wr_data_i,
  output logic [31:0] l1d_rd_data_o,
  output logic        l1d_ready_o,
  output logic        l1d_fault_o,
  output logic        fault_sticky_o,
  output logic [31:0] fault_addr_o
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [32:0] MemBytes = 33'(DEPTH) << 2;
  localparam logic [AW-1:0] LastIdx = AW'(DEPTH - 1);

  typedef enum logic {
    StClear,
    StReady
  } state_e;

  state_e        r_state;
  state_e        w_state_nxt;
  logic [AW-1:0] r_ptr;
  logic [AW-1:0] w_ptr_nxt;
  logic          w_clear_we;

  logic [31:0]   r_mem [DEPTH];

  logic          r_sticky;
  logic [31:0]   r_fault_addr;

  logic          w_ready;
  logic [31:0]   w_off;
  logic          w_in_range;
  logic [AW-1:0] w_idx;
  logic [1:0]    w_lane;
  logic          w_misaligned;
  logic          w_size_bad;
  logic          w_access_ok;
  logic          w_fault;
  logic [31:0]   w_word;
  logic [31:0]   w_shifted;
  logic [31:0]   w_rd_data;
  logic [3:0]    w_be;
  logic [31:0]   w_wr_lanes;
  logic          w_wr_commit;

  // ---------------------------------------------------------------------------
  // Clear-sweep FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= StClear;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_clear_we  = 1'b0;
    unique case (r_state)
      StClear: begin
        w_clear_we = 1'b1;
        w_ptr_nxt  = r_ptr + AW'(1);
        // Ready goes high on the same edge that writes the last word.
        if (r_ptr == LastIdx) begin
          w_state_nxt = StReady;
        end
      end
      StReady: begin
        w_state_nxt = StReady;
      end
      default: begin
        w_state_nxt = StClear;
      end
    endcase
  end

  assign w_ready = (r_state == StReady);

  // ---------------------------------------------------------------------------
  // Address decode and fault detection
  // ---------------------------------------------------------------------------
  assign w_off      = l1d_addr_i - BASE_ADDR;
  assign w_in_range = ({1'b0, w_off} < MemBytes);
  assign w_idx      = w_off[AW+1:2];
  assign w_lane     = w_off[1:0];
  assign w_size_bad = (l1d_size_i == 2'b11);

  always_comb begin
    w_misaligned = 1'b0;
    unique case (l1d_size_i)
      2'b01:   w_misaligned = w_lane[0];
      2'b10:   w_misaligned = (w_lane != 2'b00);
      default: w_misaligned = 1'b0;
    endcase
  end

  assign w_access_ok = w_in_range & ~w_misaligned & ~w_size_bad;
  assign w_fault     = w_ready & (l1d_rd_en_i | l1d_wr_en_i) & ~w_access_ok;

  // ---------------------------------------------------------------------------
  // Combinational read, right-aligned and zero-filled above the access size
  // ---------------------------------------------------------------------------
  assign w_word    = r_mem[w_idx];
  assign w_shifted = w_word >> {w_lane, 3'b000};

  always_comb begin
    w_rd_data = '0;
    if (w_ready && w_access_ok) begin
      unique case (l1d_size_i)
        2'b00:   w_rd_data = {24'h0, w_shifted[7:0]};
        2'b01:   w_rd_data = {16'h0, w_shifted[15:0]};
        2'b10:   w_rd_data = w_shifted;
        default: w_rd_data = '0;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Byte-lane write
  // ---------------------------------------------------------------------------
  always_comb begin
    w_be       = 4'b0000;
    w_wr_lanes = l1d_wr_data_i;
    unique case (l1d_size_i)
      2'b00: begin
        w_be       = 4'b0001 << w_lane;
        w_wr_lanes = {4{l1d_wr_data_i[7:0]}};
      end
      2'b01: begin
        w_be       = 4'b0011 << w_lane;
        w_wr_lanes = {2{l1d_wr_data_i[15:0]}};
      end
      2'b10: begin
        w_be       = 4'b1111;
        w_wr_lanes = l1d_wr_data_i;
      end
      default: begin
        w_be       = 4'b0000;
        w_wr_lanes = l1d_wr_data_i;
      end
    endcase
  end

  assign w_wr_commit = l1d_wr_en_i & w_ready & w_access_ok;

  // Storage has no reset; the sweep is what zeroes it.
  always_ff @(posedge clk_i) begin
    if (w_clear_we) begin
      r_mem[r_ptr] <= '0;
    end else if (w_wr_commit) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) begin
          r_mem[w_idx][8*b +: 8] <= w_wr_lanes[8*b +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // First-fault capture
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sticky     <= 1'b0;
      r_fault_addr <= '0;
    end else if (w_fault && !r_sticky) begin
      r_sticky     <= 1'b1;
      r_fault_addr <= l1d_addr_i;
    end
  end

  assign l1d_rd_data_o  = w_rd_data;
  assign l1d_ready_o    = w_ready;
  assign l1d_fault_o    = w_fault;
  assign fault_sticky_o = r_sticky;
  assign fault_addr_o   = r_fault_addr;

endmodule

// File: tb/tb_kamus_l1d_ram.sv
// Directed bench for kamus_l1d_ram with DEPTH=16: sweep timing, lane writes,
// fault capture and write dropping while not ready.
module tb_kamus_l1d_ram;

  localparam int unsigned DEPTH = 16;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        l1d_rd_en_i;
  logic        l1d_wr_en_i;
  logic [31:0] l1d_addr_i;
  logic [1:0]  l1d_size_i;
  logic [31:0] l1d_wr_data_i;
  logic [31:0] l1d_rd_data_o;
  logic        l1d_ready_o;
  logic        l1d_fault_o;
  logic        fault_sticky_o;
  logic [31:0] fault_addr_o;

  int n_pass  = 0;
  int n_total = 0;

  kamus_l1d_ram #(
    .DEPTH     (DEPTH),
    .BASE_ADDR (32'h0000_0000)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .l1d_rd_en_i    (l1d_rd_en_i),
    .l1d_wr_en_i    (l1d_wr_en_i),
    .l1d_addr_i     (l1d_addr_i),
    .l1d_size_i     (l1d_size_i),
    .l1d_wr_data_i  (l1d_wr_data_i),
    .l1d_rd_data_o  (l1d_rd_data_o),
    .l1d_ready_o    (l1d_ready_o),
    .l1d_fault_o    (l1d_fault_o),
    .fault_sticky_o (fault_sticky_o),
    .fault_addr_o   (fault_addr_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [1:0] size, input logic [31:0] data);
    l1d_rd_en_i   = rd;
    l1d_wr_en_i   = wr;
    l1d_addr_i    = addr;
    l1d_size_i    = size;
    l1d_wr_data_i = data;
    #1;
  endtask

  initial begin
    rst_ni = 1'b0;
    drive(1'b1, 1'b0, 32'h0, 2'b10, 32'h0);
    tick();
    tick();

    // Reset state
    chk("rst_ready", 32'(l1d_ready_o), 32'd0);
    chk("rst_sticky", 32'(fault_sticky_o), 32'd0);
    chk("rst_faddr", fault_addr_o, 32'h0);
    chk("rst_fault", 32'(l1d_fault_o), 32'd0);
    chk("rst_rdata", l1d_rd_data_o, 32'h0);

    // First sweep: ready after exactly DEPTH edges
    drive(1'b0, 1'b0, 32'h0, 2'b10, 32'h0);
    rst_ni = 1'b1;
    for (int c = 0; c < 18; c++) begin
      if (c == 14 || c == 15 || c == 16 || c == 17 || c == 0) begin
        chk($sformatf("sweep1_ready_c%0d", c), 32'(l1d_ready_o), (c >= 16) ? 32'd1 : 32'd0);
      end
      tick();
    end

    // Fill memory with garbage that the next sweep must clear
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 1'b1, 32'(i * 4), 2'b10, 32'hA5A5_0000 | 32'(i));
      tick();
    end
    drive(1'b1, 1'b0, 32'h14, 2'b10, 32'h0);
    chk("garbage_w5", l1d_rd_data_o, 32'hA5A5_0005);

    // Reset, write attempted during sweep, then reset again at ptr=7
    rst_ni = 1'b0;
    drive(1'b0, 1'b1, 32'h0, 2'b10, 32'h1234_5678);
    tick();
    chk("rst2_ready", 32'(l1d_ready_o), 32'd0);
    rst_ni = 1'b1;
    for (int c = 0; c < 7; c++) begin
      if (c == 3) chk("sweep_wr_nofault", 32'(l1d_fault_o), 32'd0);
      tick();
    end
    rst_ni = 1'b0;
    #2;
    rst_ni = 1'b1;
    for (int c = 0; c < 17; c++) begin
      if (c == 14) drive(1'b0, 1'b0, 32'h0, 2'b10, 32'h0);
      if (c == 0 || c == 7 || c == 15 || c == 16) begin
        chk($sformatf("sweep2_ready_c%0d", c), 32'(l1d_ready_o), (c >= 16) ? 32'd1 : 32'd0);
      end
      tick();
    end
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b0, 32'(i * 4), 2'b10, 32'h0);
      chk($sformatf("cleared_w%0d", i), l1d_rd_data_o, 32'h0);
      tick();
    end

    // Word write; same-cycle read sees old data
    drive(1'b1, 1'b1, 32'h8, 2'b10, 32'hDEAD_BEEF);
    chk("wr8_same_cycle", l1d_rd_data_o, 32'h0);
    tick();
    drive(1'b1, 1'b0, 32'h8, 2'b10, 32'h0);
    chk("rd8_word", l1d_rd_data_o, 32'hDEAD_BEEF);
    drive(1'b1, 1'b0, 32'hA, 2'b00, 32'h0);
    chk("rdA_byte", l1d_rd_data_o, 32'h0000_00AD);
    drive(1'b1, 1'b0, 32'hA, 2'b01, 32'h0);
    chk("rdA_half", l1d_rd_data_o, 32'h0000_DEAD);
    tick();

    // Byte write at 0x9; old byte visible in the write cycle
    drive(1'b1, 1'b1, 32'h9, 2'b00, 32'hFFFF_FF55);
    chk("wr9_same_cycle", l1d_rd_data_o, 32'h0000_00BE);
    tick();
    drive(1'b1, 1'b0, 32'h8, 2'b10, 32'h0);
    chk("rd8_after_byte", l1d_rd_data_o, 32'hDEAD_55EF);
    tick();

    // Back-to-back word then upper-half write
    drive(1'b0, 1'b1, 32'h0, 2'b10, 32'h1122_3344);
    tick();
    drive(1'b0, 1'b1, 32'h2, 2'b01, 32'hFFFF_AABB);
    tick();
    drive(1'b1, 1'b0, 32'h0, 2'b10, 32'h0);
    chk("rd0_after_half", l1d_rd_data_o, 32'hAABB_3344);
    tick();

    // Misaligned half write faults and is dropped
    drive(1'b0, 1'b1, 32'h5, 2'b01, 32'h0000_FFFF);
    chk("mis_fault", 32'(l1d_fault_o), 32'd1);
    chk("mis_sticky_pre", 32'(fault_sticky_o), 32'd0);
    tick();
    chk("mis_sticky", 32'(fault_sticky_o), 32'd1);
    chk("mis_faddr", fault_addr_o, 32'h5);
    drive(1'b1, 1'b0, 32'h4, 2'b10, 32'h0);
    chk("mis_mem_unchanged", l1d_rd_data_o, 32'h0);
    chk("aligned_nofault", 32'(l1d_fault_o), 32'd0);
    tick();

    // Out-of-range read: faults but first address is kept
    drive(1'b1, 1'b0, 32'h100, 2'b10, 32'h0);
    chk("oor_fault", 32'(l1d_fault_o), 32'd1);
    chk("oor_rdata", l1d_rd_data_o, 32'h0);
    tick();
    chk("oor_faddr_kept", fault_addr_o, 32'h5);

    // Range boundary
    drive(1'b1, 1'b0, 32'h3C, 2'b10, 32'h0);
    chk("last_word_nofault", 32'(l1d_fault_o), 32'd0);
    drive(1'b1, 1'b0, 32'h40, 2'b10, 32'h0);
    chk("past_end_fault", 32'(l1d_fault_o), 32'd1);

    // Reserved size
    drive(1'b1, 1'b0, 32'h0, 2'b11, 32'h0);
    chk("size11_fault", 32'(l1d_fault_o), 32'd1);
    chk("size11_rdata", l1d_rd_data_o, 32'h0);
    drive(1'b0, 1'b0, 32'h0, 2'b11, 32'h0);
    chk("size11_idle_nofault", 32'(l1d_fault_o), 32'd0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/kamus_l1d_ram.md
Name: kamus_l1d_ram

Overview:
- L1 data memory responder on the core's $L1D interface.
- The MEM stage drives the address, write enable and write data, and consumes the read data. This block serves that request side: combinational read and synchronous write with byte lanes.
- After every reset it runs a clear sweep, then raises ready.
- It flags misaligned and out-of-range accesses, and captures the first faulting address for debug.

Parameters:
- DEPTH, 1024: number of 32-bit words. Must be a power of 2 and >= 4. AW = $clog2(DEPTH).
- BASE_ADDR, 32'h0000_0000: byte address of word 0. Must be 4-byte aligned.

Ports:
- clk_i  in  1  core clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- l1d_rd_en_i  in  1  read access valid. Qualifies fault detection only.
- l1d_wr_en_i  in  1  write access valid.
- l1d_addr_i  in  32  byte address (EX result).
- l1d_size_i  in  2  access size: 00 byte, 01 half, 10 word, 11 reserved.
- l1d_wr_data_i  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- l1d_rd_data_o  out  32  load data, right-aligned, zero-filled above the access size.
- l1d_ready_o  out  1  memory usable. Requester stalls while low.
- l1d_fault_o  out  1  current access faults (combinational).
- fault_sticky_o  out  1  set on first fault since reset.
- fault_addr_o  out  32  address of the first fault.

Behaviour:
- Reset values: l1d_ready_o=0, fault_sticky_o=0, fault_addr_o=0. FSM state=CLEAR, clear pointer=0. Memory contents are not reset asynchronously; the sweep zeroes them.
- Decode:
  - off = addr - BASE_ADDR (32-bit, wraps).
  - in_range = off < DEPTH*4.
  - idx = off[AW+1:2], lane = off[1:0].
- Misaligned: half with lane[0]=1; word with lane!=0.
- l1d_fault_o = ready & (rd_en|wr_en) & (!in_range | misaligned | size==11). It is 0 while not ready.
- FSM states:
  - CLEAR: each cycle write 32'h0 to mem[ptr], ptr++. When ptr==DEPTH-1 is written, go to READY on the same edge.
  - READY: l1d_ready_o=1, registered and high from the cycle after the last clear write. Stays in READY until reset.
  - Reset asserted in any state: return to CLEAR with ptr=0; the full sweep restarts.
- Clear latency: l1d_ready_o rises exactly DEPTH rising edges after rst_ni deasserts.
- Read (combinational, zero-cycle):
  - word = mem[idx]; l1d_rd_data_o = (word >> 8*lane), masked to size (byte [7:0], half [15:0], word all), upper bits 0.
  - l1d_rd_data_o = 0 when not ready, !in_range, misaligned or size==11, regardless of rd_en.
  - The MEM stage performs sign extension.
- Write, at posedge when wr_en & ready & !fault:
  - byte: lane gets wr_data[7:0].
  - half: lanes lane and lane+1 get wr_data[15:0].
  - word: all lanes get wr_data.
  - Other lanes are unchanged.
- Writes while not ready or faulting are dropped with no memory change.
- Read-during-write to the same word: the read returns old data in that cycle; new data is visible the next cycle.
- Simultaneous rd_en and wr_en are legal: the write occurs and the read shows old data.
- fault_sticky_o/fault_addr_o:
  - On the first posedge with l1d_fault_o=1, set sticky and capture l1d_addr_i.
  - Later faults do not overwrite either until reset.
- Back-to-back accesses: one access per cycle, with no stall once ready.

Test Plan:
1. DEPTH=16: release rst_ni at cycle 0 -> l1d_ready_o=0 for cycles 0..15 and 1 from cycle 16. Reading every word returns 0 (including words preloaded with garbage before reset).
2. Word write addr 0x8, data 32'hDEADBEEF, size 10 -> next cycle read size 10 = DEADBEEF. Byte read at 0xA = 32'h0000_00AD. Half read at 0xA = 32'h0000_DEAD.
3. Byte write addr 0x9, data 32'hFFFF_FF55 over DEADBEEF -> word read = DEAD55EF. Same-cycle read of 0x8 still returns DEADBEEF.
4. Half write at 0x5 -> l1d_fault_o=1, memory unchanged, fault_sticky_o=1, fault_addr_o=0x5. A later read at 0x100 (out of range, DEPTH=16) faults, but fault_addr_o stays 0x5.
5. Write 0x12345678 at 0x0 while ready=0, and pulse rst_ni low mid-sweep at ptr=7 -> write dropped, sweep restarts, ready rises 16 cycles after the second release, and word 0 reads 0.
6. Size 11 read at 0x0 with rd_en=1 -> l1d_fault_o=1 and l1d_rd_data_o=0. The same access with rd_en=wr_en=0 -> l1d_fault_o=0.
